// File: rtl/conv_result_writer.sv
// Result-side buffer for the convolution pipeline. It grants whole-row slots to the compute
// side, stores the beats in a show-ahead FIFO and streams them out with a last flag on each row.
module conv_result_writer #(
  parameter int DATA_WIDTH         = 64,
  parameter int WIDTH_FEATURE_SIZE = 12,
  parameter int FIFO_DEPTH_LOG2    = 10,
  parameter int ROW_HEADROOM       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Start_Wr,
  input  logic [WIDTH_FEATURE_SIZE-1:0] ROW_NUM_CHANNEL_OUT_REG,
  input  logic [WIDTH_FEATURE_SIZE-1:0] COMPUTE_TIMES_CHANNEL_OUT_REG,
  input  logic                          S_Valid,
  input  logic [DATA_WIDTH-1:0]         S_Data,
  output logic                          M_ready,
  output logic                          m_tvalid,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic                          Write_Complete,
  output logic                          Err_Sticky
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;
  localparam int RBW   = 2 * WIDTH_FEATURE_SIZE;
  localparam int NW    = RBW + $clog2(ROW_HEADROOM + 1);
  localparam int CW    = (NW > PW) ? NW : PW;

  // Handshakes: a result beat is taken on S_Valid in RUN unless the FIFO is full with no
  // read in the same cycle; a downstream beat moves on m_tvalid & m_tready.
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [RBW-1:0]                r_row_beats, r_beat_cnt, w_row_beats;
  logic [NW-1:0]                 r_need;
  logic [WIDTH_FEATURE_SIZE-1:0] r_rows, r_row_cnt;
  logic [PW-1:0]                 r_wr_ptr, r_rd_ptr, r_free, w_count;
  logic [DATA_WIDTH:0]           r_mem [DEPTH];
  logic [DATA_WIDTH:0]           w_head;
  logic                          r_m_ready, r_err;
  logic                          w_empty, w_full, w_rd, w_wr;
  logic                          w_row_end, w_layer_end, w_zero_shape, w_start;

  assign w_row_beats  = RBW'(ROW_NUM_CHANNEL_OUT_REG) * RBW'(COMPUTE_TIMES_CHANNEL_OUT_REG);
  assign w_zero_shape = (ROW_NUM_CHANNEL_OUT_REG == '0) || (COMPUTE_TIMES_CHANNEL_OUT_REG == '0);
  assign w_start      = (r_state == S_IDLE) && Start_Wr;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FIFO_DEPTH_LOG2-1:0] == r_rd_ptr[FIFO_DEPTH_LOG2-1:0]) &&
                   (r_wr_ptr[FIFO_DEPTH_LOG2] != r_rd_ptr[FIFO_DEPTH_LOG2]);
  assign w_rd    = !w_empty && m_tready;
  assign w_wr    = S_Valid && (r_state == S_RUN) && (!w_full || w_rd);

  assign w_row_end   = (r_beat_cnt == r_row_beats - RBW'(1));
  assign w_layer_end = w_row_end && (r_row_cnt == r_rows - WIDTH_FEATURE_SIZE'(1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (Start_Wr) w_state_nxt = S_SETUP;
      S_SETUP: w_state_nxt = w_zero_shape ? S_DONE : S_RUN;
      S_RUN:   if (w_wr && w_layer_end) w_state_nxt = S_DRAIN;
      // Leave while the final beat is being taken so Write_Complete follows it by one cycle.
      S_DRAIN: if (w_empty || (w_count == PW'(1) && w_rd)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_beat_cnt  <= '0;
      r_row_cnt   <= '0;
      r_row_beats <= '0;
      r_need      <= '0;
      r_rows      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_free      <= PW'(DEPTH);
      r_m_ready   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_beat_cnt <= '0;
        r_row_cnt  <= '0;
      end else if (w_wr) begin
        if (w_row_end) begin
          r_beat_cnt <= '0;
          r_row_cnt  <= r_row_cnt + WIDTH_FEATURE_SIZE'(1);
        end else begin
          r_beat_cnt <= r_beat_cnt + RBW'(1);
        end
      end
      if (r_state == S_SETUP) begin
        r_row_beats <= w_row_beats;
        r_need      <= NW'(ROW_HEADROOM) * NW'(w_row_beats);
        r_rows      <= ROW_NUM_CHANNEL_OUT_REG;
      end
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_free <= r_free - PW'(w_wr) + PW'(w_rd);
      if (w_start)                r_err <= 1'b0;
      else if (S_Valid && !w_wr)  r_err <= 1'b1;
      // Uses last cycle's free count, so the grant lags occupancy by one cycle on the safe side.
      r_m_ready <= (r_state == S_RUN) && (r_row_cnt < r_rows) && (CW'(r_free) >= CW'(r_need));
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= {w_row_end, S_Data};
  end

  assign w_head         = r_mem[r_rd_ptr[FIFO_DEPTH_LOG2-1:0]];
  assign m_tvalid       = !w_empty;
  assign m_tdata        = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
  assign m_tlast        = !w_empty && w_head[DATA_WIDTH];
  assign M_ready        = r_m_ready;
  assign Write_Complete = (r_state == S_DONE);
  assign Err_Sticky     = r_err;
endmodule

// File: tb/tb_conv_result_writer.sv
// Bench for conv_result_writer: random layers against a queue-based reference of the
// result stream, grant level, completion pulse and error flag.
`timescale 1ns/1ps
module tb_conv_result_writer;
  localparam int DW    = 16;
  localparam int FW    = 12;
  localparam int LOG2  = 4;
  localparam int HR    = 2;
  localparam int DEPTH = 1 << LOG2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          Start_Wr = 1'b0;
  logic [FW-1:0] row_num = '0;
  logic [FW-1:0] out_num = '0;
  logic          S_Valid = 1'b0;
  logic [DW-1:0] S_Data = '0;
  logic          m_tready = 1'b0;
  logic          M_ready, m_tvalid, m_tlast, Write_Complete, Err_Sticky;
  logic [DW-1:0] m_tdata;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int tr_mode   = 2;
  int data_mode = 0;

  conv_result_writer #(
    .DATA_WIDTH(DW), .WIDTH_FEATURE_SIZE(FW), .FIFO_DEPTH_LOG2(LOG2), .ROW_HEADROOM(HR)
  ) dut (
    .clk(clk), .rst(rst), .Start_Wr(Start_Wr),
    .ROW_NUM_CHANNEL_OUT_REG(row_num), .COMPUTE_TIMES_CHANNEL_OUT_REG(out_num),
    .S_Valid(S_Valid), .S_Data(S_Data), .M_ready(M_ready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .Write_Complete(Write_Complete), .Err_Sticky(Err_Sticky)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference ----------------
  // Each entry is {last, data}; the queue is the FIFO contents as the consumer should see them.
  logic [DW:0] exp_q[$];
  int  cyc = 0, start_cyc = 0, wc_due = -1;
  int  acc = 0, popped = 0, total = 0, rb = 0, rows = 0;
  bit  active = 0, model_on = 0, after_rst = 0, m_err = 0, exp_mready = 0;

  always @(negedge clk) begin
    bit run, rd, wr, lst;
    if (model_on) begin
      check("m_tvalid", m_tvalid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("m_tdata", m_tdata, exp_q[0][DW-1:0]);
        check("m_tlast", m_tlast, exp_q[0][DW]);
      end
      check("m_ready", M_ready, exp_mready);
      check("write_complete", Write_Complete, cyc == wc_due);
      check("err_sticky", Err_Sticky, m_err);
      if (after_rst) begin
        check("rst_tdata", m_tdata, 0);
        check("rst_tlast", m_tlast, 0);
      end
    end
    if (rst) begin
      exp_q.delete();
      active = 0; m_err = 0; exp_mready = 0; wc_due = -1;
      model_on = 1; after_rst = 1;
    end else if (model_on) begin
      after_rst = 0;
      run = active && (cyc >= start_cyc + 2) && (acc < total);
      rd  = (exp_q.size() != 0) && m_tready;
      wr  = S_Valid && run && ((exp_q.size() < DEPTH) || rd);
      exp_mready = run && ((DEPTH - exp_q.size()) >= HR * rb);
      if (S_Valid && !wr) m_err = 1;
      if (rd) begin
        void'(exp_q.pop_front());
        popped++;
        if (active && popped == total) wc_due = cyc + 1;
      end
      if (wr) begin
        lst = ((acc % rb) == rb - 1);
        exp_q.push_back({lst, S_Data});
        acc++;
      end
      if (Start_Wr && !active) begin
        active = 1; start_cyc = cyc; acc = 0; popped = 0; m_err = 0;
        rows = int'(row_num); rb = int'(row_num) * int'(out_num); total = rows * rb;
        if (total == 0) wc_due = cyc + 2;
      end else if (active && cyc == wc_due) begin
        active = 0;
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      case (tr_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(0, 3) != 0);
        default: m_tready = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    S_Valid = 1'b0; Start_Wr = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_layer(input int r, input int o);
    row_num = FW'(r); out_num = FW'(o); Start_Wr = 1'b1;
    tick();
    Start_Wr = 1'b0;
  endtask

  // Compute-side emulation: sample M_ready once per row, then stream the row without a gap.
  task automatic drive_layer(input int r, input int o, input int stop_after);
    int rbeats = r * o;
    int sent = 0;
    for (int row = 0; row < r; row++) begin
      int g = 0;
      while (!M_ready) begin
        tick(); g++;
        if (g > 3000) begin check("m_ready_timeout", 0, 1); return; end
      end
      for (int b = 0; b < rbeats; b++) begin
        if (stop_after >= 0 && sent == stop_after) begin S_Valid = 1'b0; return; end
        S_Valid = 1'b1;
        S_Data  = (data_mode == 0) ? DW'(sent) : DW'($urandom);
        sent++;
        tick();
      end
      S_Valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (!Write_Complete && g < 3000) begin tick(); g++; end
    check(tag, Write_Complete, 1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) tick();

    // basic layer, beat index data, always-ready sink
    tr_mode = 0; data_mode = 0;
    start_layer(4, 2);
    drive_layer(4, 2, -1);
    wait_done("basic_done");
    check("basic_err", Err_Sticky, 0);

    // back-pressure: sink stalls while two rows would not fit
    tr_mode = 2; data_mode = 1;
    start_layer(4, 2);
    fork
      drive_layer(4, 2, -1);
      begin
        int g = 0;
        while (exp_q.size() < 8 && g < 500) begin tick(); g++; end
        check("bp_fill", m_tvalid, 1);
        repeat (20) begin tick(); check("bp_mready_low", M_ready, 0); end
        tr_mode = 0;
      end
    join
    wait_done("bp_done");

    // random shapes with a random sink
    repeat (6) begin
      int r = $urandom_range(1, 4);
      int o = $urandom_range(1, 8 / r);
      tr_mode = 1;
      start_layer(r, o);
      drive_layer(r, o, -1);
      wait_done("rand_done");
    end

    // overflow: 17 beats into 16 entries with the sink stalled
    tr_mode = 2; data_mode = 0;
    start_layer(4, 8);
    tick();
    for (int i = 0; i < DEPTH + 1; i++) begin
      S_Valid = 1'b1; S_Data = DW'(i);
      tick();
    end
    S_Valid = 1'b0;
    check("ovf_err", Err_Sticky, 1);
    check("ovf_head", m_tdata, 0);
    tr_mode = 0;
    repeat (DEPTH + 4) tick();
    check("ovf_drained", m_tvalid, 0);
    do_reset();

    // stray beat while idle, cleared by the next start
    tick();
    S_Valid = 1'b1; S_Data = 16'h5a5a;
    tick();
    S_Valid = 1'b0;
    tick();
    check("stray_err", Err_Sticky, 1);
    check("stray_nowrite", m_tvalid, 0);
    tr_mode = 1;
    start_layer(2, 2);
    check("stray_cleared", Err_Sticky, 0);
    drive_layer(2, 2, -1);
    wait_done("stray_done");

    // reset three beats into row 1
    tr_mode = 1; data_mode = 1;
    start_layer(3, 2);
    drive_layer(3, 2, 9);
    do_reset();
    check("mid_rst_mready", M_ready, 0);
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_wc", Write_Complete, 0);
    check("mid_rst_err", Err_Sticky, 0);
    start_layer(3, 2);
    drive_layer(3, 2, -1);
    wait_done("post_rst_done");

    // degenerate shapes
    start_layer(0, 2);
    wait_done("zero_rows_done");
    start_layer(2, 0);
    wait_done("zero_out_done");

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #2000000;
    check("watchdog", 0, 1);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
